// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - job sequencer between the APB slave and the matmul engine
// Optional RUN-phase watchdog: define MATMUL_SEQ_WDT_EN.
module matmul_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int OPA_BASE   = 'h00,
    parameter int OPB_BASE   = 'h08,
    parameter int SP_BASE    = 'h10,
    parameter int FLAGS_ADDR = 'h0C,
    parameter int WDT_CYCLES = 256,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            dim_n_i,
    input  logic [1:0]            dim_k_i,
    input  logic [1:0]            dim_m_i,
    input  logic                  apb_busy_i,
    input  logic [ADDR_WIDTH-1:0] apb_addr_i,
    input  logic [BUS_WIDTH-1:0]  apb_wdata_i,
    input  logic [MAX_DIM-1:0]    apb_strb_i,
    input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
    input  logic                  eng_done_i,
    input  logic                  eng_ovf_i,
    input  logic [BUS_WIDTH-1:0]  eng_res_i,
    output logic                  busy_o,
    output logic                  start_clr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [BUS_WIDTH-1:0]  mem_wdata_o,
    output logic [MAX_DIM-1:0]    mem_strb_o,
    output logic                  mem_rd_o,
    output logic                  eng_ld_o,
    output logic                  eng_sel_o,
    output logic [1:0]            eng_row_o,
    output logic                  eng_start_o
);

    localparam int STRIDE = BUS_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_RUN,
        S_STORE,
        S_FLAGS,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic       armed_q;
    logic [1:0] dim_n_q, dim_k_q, dim_m_q;
    logic       dimerr_q, ovf_q, tmo_q;
    logic       rd_sel_q, rd_done_q;
    logic [1:0] rd_row_q;
    logic       ld_q, ld_sel_q;
    logic [1:0] ld_row_q;
    logic       started_q;
    logic [1:0] st_row_q;
    logic       dim_err_c;
    logic       wdt_hit;
    logic [MAX_DIM-1:0] m_mask;

    // Operand data flows straight from memory to the engine; the sequencer never looks at it.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata_i;

`ifdef MATMUL_SEQ_WDT_EN
    logic [31:0] wdt_cnt_q;
    assign wdt_hit = (wdt_cnt_q == 32'(WDT_CYCLES - 1));
`else
    localparam int wdt_unused = WDT_CYCLES;
    assign wdt_hit = 1'b0;
`endif

    function automatic logic [ADDR_WIDTH-1:0] row_addr(input int base, input logic [1:0] row);
        return ADDR_WIDTH'(base + int'(row) * STRIDE);
    endfunction

    assign dim_err_c = (int'(dim_n_q) > MAX_DIM - 1) || (int'(dim_k_q) > MAX_DIM - 1) ||
                       (int'(dim_m_q) > MAX_DIM - 1);

    always_comb begin
        m_mask = '0;
        for (int j = 0; j < MAX_DIM; j++) begin
            m_mask[j] = (j <= int'(dim_m_q));
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b1;
        start_clr_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;
        mem_rd_o    = 1'b0;
        eng_ld_o    = ld_q;
        eng_sel_o   = 1'b0;
        eng_row_o   = 2'd0;
        eng_start_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_o      = 1'b0;
                mem_addr_o  = apb_addr_i;
                mem_wdata_o = apb_wdata_i;
                mem_strb_o  = apb_strb_i;
                if (start_i && armed_q && !apb_busy_i) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = dim_err_c ? S_FLAGS : S_LOAD;
            end
            S_LOAD: begin
                mem_rd_o   = !rd_done_q;
                mem_addr_o = row_addr(rd_sel_q ? OPB_BASE : OPA_BASE, rd_row_q);
                eng_sel_o  = ld_sel_q;
                eng_row_o  = ld_row_q;
                if (ld_q && ld_sel_q && (ld_row_q == dim_k_q)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                eng_start_o = !started_q;
                if (eng_done_i) begin
                    state_d = S_STORE;
                end else if (wdt_hit) begin
                    state_d = S_FLAGS;
                end
            end
            S_STORE: begin
                mem_addr_o  = row_addr(SP_BASE, st_row_q);
                mem_wdata_o = eng_res_i;
                mem_strb_o  = m_mask;
                eng_row_o   = st_row_q;
                if (st_row_q == dim_n_q) begin
                    state_d = S_FLAGS;
                end
            end
            S_FLAGS: begin
                mem_addr_o  = ADDR_WIDTH'(FLAGS_ADDR);
                mem_wdata_o = BUS_WIDTH'({tmo_q, ovf_q, dimerr_q, ~tmo_q});
                mem_strb_o  = '1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                start_clr_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b1;
            dim_n_q   <= 2'd0;
            dim_k_q   <= 2'd0;
            dim_m_q   <= 2'd0;
            dimerr_q  <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            rd_sel_q  <= 1'b0;
            rd_done_q <= 1'b0;
            rd_row_q  <= 2'd0;
            ld_q      <= 1'b0;
            ld_sel_q  <= 1'b0;
            ld_row_q  <= 2'd0;
            started_q <= 1'b0;
            st_row_q  <= 2'd0;
`ifdef MATMUL_SEQ_WDT_EN
            wdt_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ld_q     <= mem_rd_o;
            ld_sel_q <= rd_sel_q;
            ld_row_q <= rd_row_q;
            if (!start_i) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_CHECK) begin
                        armed_q  <= 1'b0;
                        dim_n_q  <= dim_n_i;
                        dim_k_q  <= dim_k_i;
                        dim_m_q  <= dim_m_i;
                        dimerr_q <= 1'b0;
                        ovf_q    <= 1'b0;
                        tmo_q    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    rd_sel_q  <= 1'b0;
                    rd_row_q  <= 2'd0;
                    rd_done_q <= 1'b0;
                    started_q <= 1'b0;
                    st_row_q  <= 2'd0;
                    dimerr_q  <= dim_err_c;
`ifdef MATMUL_SEQ_WDT_EN
                    wdt_cnt_q <= '0;
`endif
                end
                S_LOAD: begin
                    // A rows first, then B rows; the last B read parks the reader.
                    if (!rd_done_q) begin
                        if (!rd_sel_q) begin
                            if (rd_row_q == dim_n_q) begin
                                rd_sel_q <= 1'b1;
                                rd_row_q <= 2'd0;
                            end else begin
                                rd_row_q <= rd_row_q + 2'd1;
                            end
                        end else if (rd_row_q == dim_k_q) begin
                            rd_done_q <= 1'b1;
                        end else begin
                            rd_row_q <= rd_row_q + 2'd1;
                        end
                    end
                end
                S_RUN: begin
                    started_q <= 1'b1;
                    if (eng_done_i) begin
                        ovf_q <= eng_ovf_i;
                    end else if (wdt_hit) begin
                        tmo_q <= 1'b1;
                    end
`ifdef MATMUL_SEQ_WDT_EN
                    wdt_cnt_q <= wdt_cnt_q + 32'd1;
`endif
                end
                S_STORE: begin
                    if (st_row_q != dim_n_q) begin
                        st_row_q <= st_row_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
